// File: rtl/ysyx_23060191_regfile_pkg.sv
// rtl/ysyx_23060191_regfile_pkg.sv - shared GPR widths, register indices and sizing helper
package ysyx_23060191_regfile_pkg;

    localparam int CPU_WIDTH  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int GPR_NUM    = 1 << REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] X0  = 5'd0;
    localparam logic [REG_ADDR_W-1:0] X1  = 5'd1;
    localparam logic [REG_ADDR_W-1:0] X2  = 5'd2;
    localparam logic [REG_ADDR_W-1:0] X3  = 5'd3;
    localparam logic [REG_ADDR_W-1:0] X4  = 5'd4;
    localparam logic [REG_ADDR_W-1:0] X5  = 5'd5;
    localparam logic [REG_ADDR_W-1:0] X6  = 5'd6;
    localparam logic [REG_ADDR_W-1:0] X7  = 5'd7;
    localparam logic [REG_ADDR_W-1:0] X8  = 5'd8;
    localparam logic [REG_ADDR_W-1:0] X9  = 5'd9;
    localparam logic [REG_ADDR_W-1:0] X10 = 5'd10;
    localparam logic [REG_ADDR_W-1:0] X11 = 5'd11;
    localparam logic [REG_ADDR_W-1:0] X12 = 5'd12;
    localparam logic [REG_ADDR_W-1:0] X13 = 5'd13;
    localparam logic [REG_ADDR_W-1:0] X14 = 5'd14;
    localparam logic [REG_ADDR_W-1:0] X15 = 5'd15;
    localparam logic [REG_ADDR_W-1:0] X16 = 5'd16;
    localparam logic [REG_ADDR_W-1:0] X17 = 5'd17;
    localparam logic [REG_ADDR_W-1:0] X18 = 5'd18;
    localparam logic [REG_ADDR_W-1:0] X19 = 5'd19;
    localparam logic [REG_ADDR_W-1:0] X20 = 5'd20;
    localparam logic [REG_ADDR_W-1:0] X21 = 5'd21;
    localparam logic [REG_ADDR_W-1:0] X22 = 5'd22;
    localparam logic [REG_ADDR_W-1:0] X23 = 5'd23;
    localparam logic [REG_ADDR_W-1:0] X24 = 5'd24;
    localparam logic [REG_ADDR_W-1:0] X25 = 5'd25;
    localparam logic [REG_ADDR_W-1:0] X26 = 5'd26;
    localparam logic [REG_ADDR_W-1:0] X27 = 5'd27;
    localparam logic [REG_ADDR_W-1:0] X28 = 5'd28;
    localparam logic [REG_ADDR_W-1:0] X29 = 5'd29;
    localparam logic [REG_ADDR_W-1:0] X30 = 5'd30;
    localparam logic [REG_ADDR_W-1:0] X31 = 5'd31;

    // Register count for a given address width (16 for RV32E, 32 for RV32I).
    function automatic int nregs(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/ysyx_23060191_scoreboard.sv
// rtl/ysyx_23060191_scoreboard.sv - per-register busy bits set at issue, cleared at writeback
module ysyx_23060191_scoreboard
    import ysyx_23060191_regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NR_RD  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    set_en,
    input  logic [ADDR_W-1:0]       set_addr,
    input  logic                    clr_en,
    input  logic [ADDR_W-1:0]       clr_addr,
    input  logic [NR_RD*ADDR_W-1:0] lk_addr,
    output logic [NR_RD-1:0]        lk_busy
);

    localparam int NREGS = nregs(ADDR_W);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (clr_en && (clr_addr != '0)) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar gi = 0; gi < NR_RD; gi++) begin : g_lk
        assign lk_busy[gi] = busy_q[lk_addr[gi*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/ysyx_23060191_regfile.sv
// rtl/ysyx_23060191_regfile.sv - clocked GPR file with bypassed read ports and RAW scoreboard
module ysyx_23060191_regfile
    import ysyx_23060191_regfile_pkg::*;
#(
    parameter int DATA_W = CPU_WIDTH,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NR_RD  = 2,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wen,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [NR_RD*ADDR_W-1:0] raddr,
    output logic [NR_RD*DATA_W-1:0] rdata,
    output logic [NR_RD-1:0]        rd_busy,
    input  logic                    busy_set,
    input  logic [ADDR_W-1:0]       busy_addr,
    input  logic [ADDR_W-1:0]       dbg_addr,
    output logic [DATA_W-1:0]       dbg_data
);

    localparam int NREGS = nregs(ADDR_W);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_en;
    logic [NR_RD-1:0]  sb_busy;

    assign wr_en = wen && (waddr != '0);

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    ysyx_23060191_scoreboard #(
        .ADDR_W (ADDR_W),
        .NR_RD  (NR_RD)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (busy_set),
        .set_addr (busy_addr),
        .clr_en   (wen),
        .clr_addr (waddr),
        .lk_addr  (raddr),
        .lk_busy  (sb_busy)
    );

    // A port hitting the in-flight write sees its data and no longer waits on it.
    for (genvar gi = 0; gi < NR_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;

        assign ra  = raddr[gi*ADDR_W +: ADDR_W];
        assign hit = (BYPASS != 0) && wr_en && (waddr == ra);
        assign rdata[gi*DATA_W +: DATA_W] = (ra == '0) ? '0 :
                                            hit        ? wdata : regs_q[ra];
        assign rd_busy[gi] = sb_busy[gi] & ~hit;
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_ysyx_23060191_regfile.sv
// tb/tb_ysyx_23060191_regfile.sv - scoreboard bench for default, no-bypass and RV32E regfiles
module tb_ysyx_23060191_regfile;

    typedef struct {
        logic [31:0] m_rd0, m_rd1, m_dbg;
        logic [1:0]  m_busy;
        logic [31:0] n_rd0, n_rd1, n_dbg;
        logic [1:0]  n_busy;
        logic [31:0] e_rd0, e_rd1, e_rd2, e_dbg;
        logic [2:0]  e_busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, wen, bset;
    logic [4:0]  waddr, baddr, dbga, ra0, ra1, ra2;
    logic [31:0] wdata;

    logic [63:0] rdata_m, rdata_n;
    logic [1:0]  busy_m, busy_n;
    logic [31:0] dbg_m, dbg_n, dbg_e;
    logic [95:0] rdata_e;
    logic [2:0]  busy_e;

    logic [31:0] mem_m [32];
    bit          bz_m  [32];
    logic [31:0] mem_e [16];
    bit          bz_e  [16];
    bit          model_ok = 1'b0;

    exp_t q[$];
    exp_t mon_x;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ysyx_23060191_regfile u_m (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr({ra1, ra0}), .rdata(rdata_m), .rd_busy(busy_m),
        .busy_set(bset), .busy_addr(baddr), .dbg_addr(dbga), .dbg_data(dbg_m)
    );

    ysyx_23060191_regfile #(.BYPASS(0)) u_n (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr({ra1, ra0}), .rdata(rdata_n), .rd_busy(busy_n),
        .busy_set(bset), .busy_addr(baddr), .dbg_addr(dbga), .dbg_data(dbg_n)
    );

    ysyx_23060191_regfile #(.ADDR_W(4), .NR_RD(3)) u_e (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr[3:0]), .wdata(wdata),
        .raddr({ra2[3:0], ra1[3:0], ra0[3:0]}), .rdata(rdata_e), .rd_busy(busy_e),
        .busy_set(bset), .busy_addr(baddr[3:0]), .dbg_addr(dbga[3:0]), .dbg_data(dbg_e)
    );

    // Reference view: what a reader of register a sees this cycle.
    function automatic logic [31:0] exp_rd(input bit e, input bit byp, input logic [4:0] a);
        logic [4:0] aa, wa;
        aa = e ? {1'b0, a[3:0]} : a;
        wa = e ? {1'b0, waddr[3:0]} : waddr;
        if (aa == 5'd0) return 32'd0;
        if (byp && wen && (wa == aa)) return wdata;
        return e ? mem_e[aa[3:0]] : mem_m[aa];
    endfunction

    function automatic logic exp_bz(input bit e, input bit byp, input logic [4:0] a);
        logic [4:0] aa, wa;
        aa = e ? {1'b0, a[3:0]} : a;
        wa = e ? {1'b0, waddr[3:0]} : waddr;
        if (aa == 5'd0) return 1'b0;
        if (byp && wen && (wa == aa)) return 1'b0;
        return e ? bz_e[aa[3:0]] : bz_m[aa];
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, ex);
        end
    endtask

    task automatic cyc(input bit r, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input bit bs, input logic [4:0] ba, input logic [4:0] da);
        exp_t x;
        rst_n = r; wen = w; waddr = wa; wdata = wd;
        ra0 = a0; ra1 = a1; ra2 = a2; bset = bs; baddr = ba; dbga = da;
        if (model_ok) begin
            x.m_rd0  = exp_rd(0, 1, a0);
            x.m_rd1  = exp_rd(0, 1, a1);
            x.m_dbg  = exp_rd(0, 0, da);
            x.m_busy = {exp_bz(0, 1, a1), exp_bz(0, 1, a0)};
            x.n_rd0  = exp_rd(0, 0, a0);
            x.n_rd1  = exp_rd(0, 0, a1);
            x.n_dbg  = exp_rd(0, 0, da);
            x.n_busy = {exp_bz(0, 0, a1), exp_bz(0, 0, a0)};
            x.e_rd0  = exp_rd(1, 1, a0);
            x.e_rd1  = exp_rd(1, 1, a1);
            x.e_rd2  = exp_rd(1, 1, a2);
            x.e_dbg  = exp_rd(1, 0, da);
            x.e_busy = {exp_bz(1, 1, a2), exp_bz(1, 1, a1), exp_bz(1, 1, a0)};
            q.push_back(x);
        end
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < 32; i++) begin mem_m[i] = 0; bz_m[i] = 0; end
            for (int i = 0; i < 16; i++) begin mem_e[i] = 0; bz_e[i] = 0; end
            model_ok = 1'b1;
        end else begin
            if (w && wa != 0) begin mem_m[wa] = wd; bz_m[wa] = 0; end
            if (bs && ba != 0) bz_m[ba] = 1;
            if (w && wa[3:0] != 0) begin mem_e[wa[3:0]] = wd; bz_e[wa[3:0]] = 0; end
            if (bs && ba[3:0] != 0) bz_e[ba[3:0]] = 1;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_x = q.pop_front();
            chk("m_rd0",  rdata_m[31:0],  mon_x.m_rd0);
            chk("m_rd1",  rdata_m[63:32], mon_x.m_rd1);
            chk("m_dbg",  dbg_m,          mon_x.m_dbg);
            chk("m_busy", {30'd0, busy_m}, {30'd0, mon_x.m_busy});
            chk("n_rd0",  rdata_n[31:0],  mon_x.n_rd0);
            chk("n_rd1",  rdata_n[63:32], mon_x.n_rd1);
            chk("n_dbg",  dbg_n,          mon_x.n_dbg);
            chk("n_busy", {30'd0, busy_n}, {30'd0, mon_x.n_busy});
            chk("e_rd0",  rdata_e[31:0],  mon_x.e_rd0);
            chk("e_rd1",  rdata_e[63:32], mon_x.e_rd1);
            chk("e_rd2",  rdata_e[95:64], mon_x.e_rd2);
            chk("e_dbg",  dbg_e,          mon_x.e_dbg);
            chk("e_busy", {29'd0, busy_e}, {29'd0, mon_x.e_busy});
        end
    end

    initial begin
        logic [4:0] wa, r0, r1;
        rst_n = 0; wen = 0; waddr = 0; wdata = 0; ra0 = 0; ra1 = 0; ra2 = 0;
        bset = 0; baddr = 0; dbga = 0;
        @(posedge clk); #1;
        cyc(0, 1, 5'd4, 32'h1111, 0, 0, 0, 1, 5'd4, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 32; a++)
            cyc(1, 0, 0, 0, 5'(a), 5'(31 - a), 5'(a + 7), 0, 0, 5'(a));
        cyc(1, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, 0, 0, 5'd5);
        cyc(1, 0, 0, 0, 5'd5, 5'd6, 5'd5, 0, 0, 5'd5);
        cyc(1, 1, 5'd0, 32'h1234, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 5'd7, 32'h0BAD0007, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 5'd7, 0, 0, 5'd7);
        cyc(1, 0, 0, 0, 5'd7, 5'd7, 5'd7, 0, 0, 5'd7);
        cyc(1, 0, 0, 0, 0, 5'd10, 5'd10, 1, 5'd10, 0);
        cyc(1, 0, 0, 0, 0, 5'd10, 5'd10, 0, 0, 0);
        cyc(1, 1, 5'd10, 32'hCAFE000A, 5'd10, 5'd10, 5'd10, 0, 0, 5'd10);
        cyc(1, 0, 0, 0, 5'd10, 5'd10, 5'd10, 0, 0, 5'd10);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 5'd12, 0);
        cyc(1, 1, 5'd12, 32'h0000C0DE, 5'd12, 5'd12, 5'd12, 1, 5'd12, 5'd12);
        cyc(1, 0, 0, 0, 5'd12, 5'd12, 5'd12, 0, 0, 5'd12);
        cyc(1, 1, 5'd3, 32'h55, 0, 0, 0, 1, 5'd3, 0);
        cyc(1, 0, 0, 0, 5'd3, 5'd3, 5'd3, 0, 0, 5'd3);
        cyc(0, 1, 5'd3, 32'h66, 5'd3, 5'd3, 5'd3, 1, 5'd3, 5'd3);
        cyc(1, 0, 0, 0, 5'd3, 5'd3, 5'd3, 0, 0, 5'd3);
        for (int n = 0; n < 800; n++) begin
            wa = 5'($urandom_range(0, 31));
            r0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), wa, $urandom,
                r0, r1, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060191_regfile.md
Name: ysyx_23060191_regfile

Overview:
Clocked, parametrised general-purpose register file that replaces the combinational GPR. It has NR_RD combinational read ports, one synchronous write port with enable, optional write-to-read bypass, and x0 hardwired to zero. It also contains a per-register busy scoreboard: decode sets a bit when an instruction is issued, and writeback clears it, so the pipeline can detect RAW hazards. It sits between decode (read/busy_set) and writeback (write).

Parameters:
DATA_W, 32, register width in bits (CPU_WIDTH)
ADDR_W, 5, address width; NREGS = 2**ADDR_W (4 gives RV32E, 16 regs)
NR_RD, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read returns stored value

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
wen  in  1  write enable (writeback valid)
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
raddr  in  NR_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rdata  out  NR_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
rd_busy  out  NR_RD  1 = register on port i has an outstanding producer
busy_set  in  1  issue: mark busy_addr as pending
busy_addr  in  ADDR_W  destination register of issuing instruction
dbg_addr  in  ADDR_W  debug/difftest read address
dbg_data  out  DATA_W  stored value at dbg_addr, never bypassed

Behaviour:
- Reset (rst_n=0 at posedge): all NREGS registers = 0 and all busy bits = 0. The reset is synchronous only; the registers are unaffected between edges. Reset wins over concurrent wen and busy_set.
- Outputs are combinational from state and inputs. After reset: rdata = 0, rd_busy = 0, dbg_data = 0.
- Write: at posedge with rst_n=1, wen=1 and waddr!=0, reg[waddr] <= wdata. Writes to x0 are discarded.
- Read latency is 0 cycles. rdata_i = 0 if raddr_i==0. Otherwise, if BYPASS=1 and wen=1 and waddr==raddr_i, rdata_i = wdata. Otherwise rdata_i = reg[raddr_i].
- Multiple ports may read the same address. Each port bypasses independently.
- Scoreboard set: busy_set=1 and busy_addr!=0 sets busy[busy_addr] at posedge. A set on x0 is ignored; busy[0] is constantly 0.
- Scoreboard clear: wen=1 and waddr!=0 clears busy[waddr] at posedge.
- Set and clear of the same address in the same cycle: set wins, busy stays 1, because the new producer supersedes the old one. Set and clear of different addresses both take effect.
- Setting an already-busy register leaves it at 1 (no counting; one outstanding producer per register is guaranteed by the issue logic).
- rd_busy_i = busy[raddr_i]. When BYPASS=1 and the bypass condition holds for port i, rd_busy_i is forced to 0 in the same cycle.
- dbg_data = reg[dbg_addr], with 0 for address 0. It reflects committed state only.
- No X propagation: every output is defined for every address value.

Decomposition:
- Shared defines header: CPU_WIDTH and the X0..X31 register indices. Also add REG_ADDR_W (5) and a GPR_NUM constant.
- Sub-module ysyx_23060191_scoreboard: NREGS busy bits with the set/clear/priority logic and NR_RD lookup ports. It is instantiated once by the regfile.
- Read-port muxes are generated with a generate loop over NR_RD. There is no per-index case statement.

Test Plan:
- Reset then read: hold rst_n=0 for 2 cycles, release, read all 32 addresses via port0, port1 and dbg -> all 0, and rd_busy=0.
- Write/read: write x5=0xDEADBEEF, then next cycle raddr0=5 -> 0xDEADBEEF and dbg_data=0xDEADBEEF. Write x0=0x1234 -> reading x0 on all ports returns 0.
- Bypass: with BYPASS=1, wen=1, waddr=7, wdata=0xA5A5A5A5, raddr0=raddr1=7 in the same cycle -> both rdata=0xA5A5A5A5, dbg_data still the old value. With BYPASS=0 -> old value until the next cycle.
- Scoreboard: busy_set x10, then raddr1=10 -> rd_busy[1]=1. Next, wen x10 -> same cycle rd_busy[1]=0 (bypass) and the following cycle busy clear. busy_set x0 -> rd_busy stays 0.
- Same-cycle set+clear: x12 busy; wen x12 and busy_set x12 together -> busy[12]=1 after the edge, and reg[12] updated.
- Reset mid-operation: x3=0x55 and x3 busy, then assert rst_n=0 for one edge alongside wen x3=0x66 -> x3=0, busy[3]=0. With RV32E config (ADDR_W=4, NR_RD=3), repeat the write/read test.
